core_task_receiver: RTL and testbench

// Per-core receiver sitting directly downstream of the task scheduler: one instance per core.
// On its Start bit it captures the broadcast instruction frames into a local instruction buffer
// and latches the optional R0 initial value. It then hands the task to the core and reports

---
 rtl/core_task_receiver.sv | 161 ++++++++++++++++
 tb/tb_core_task_receiver.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_task_receiver.sv
// Per-core task receiver: captures broadcast instruction frames on Start,
// latches R0 init value, runs the core and reports Ready on completion.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   Start, Init_R0_Vect      scheduler vectors, bit CORE_ID used
//   Init_R0                  packed R0 values, slice CORE_ID used
//   Insn_Valid/Last/Data     broadcast instruction frame stream
//   Ready, Core_Run          task handshake toward scheduler / core
//   Core_Done                core completion (sampled in RUN only)
//   Fetch_Addr, Fetch_Insn   combinational instruction fetch port
//   R0_Init_Valid/Value      latched R0 initialisation request
//   Frames_Loaded, Overflow  capture status for the current task
module core_task_receiver #(
    parameter int CORE_ID     = 0,
    parameter int CORES_COUNT = 16,
    parameter int INSN_COUNT  = 16,
    parameter int INSN_SIZE   = 16,
    parameter int REG_SIZE    = 8,
    parameter int MAX_FRAMES  = 4
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [CORES_COUNT-1:0]                    Start,
    input  logic [CORES_COUNT-1:0]                    Init_R0_Vect,
    input  logic [CORES_COUNT*REG_SIZE-1:0]           Init_R0,
    input  logic                                      Insn_Valid,
    input  logic                                      Insn_Last,
    input  logic [INSN_COUNT*INSN_SIZE-1:0]           Insn_Data,
    output logic                                      Ready,
    output logic                                      Core_Run,
    input  logic                                      Core_Done,
    input  logic [$clog2(MAX_FRAMES*INSN_COUNT)-1:0]  Fetch_Addr,
    output logic [INSN_SIZE-1:0]                      Fetch_Insn,
    output logic                                      R0_Init_Valid,
    output logic [REG_SIZE-1:0]                       R0_Init_Value,
    output logic [$clog2(MAX_FRAMES+1)-1:0]           Frames_Loaded,
    output logic                                      Overflow
);

    localparam int FW      = $clog2(MAX_FRAMES + 1);
    localparam int FIW     = (MAX_FRAMES > 1) ? $clog2(MAX_FRAMES) : 1;
    localparam int KW      = (INSN_COUNT > 1) ? $clog2(INSN_COUNT) : 1;
    localparam int FRAME_W = INSN_COUNT * INSN_SIZE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [FW-1:0]         frames_q, frames_d;
    logic                  ovf_q, ovf_d;
    logic                  r0v_q, r0v_d;
    logic [REG_SIZE-1:0]   r0val_q, r0val_d;
    logic                  wr_en;

    // One buffer row per frame; a frame is written in a single cycle.
    logic [FRAME_W-1:0]    buf_q [MAX_FRAMES];

    logic                  start_me;
    logic [REG_SIZE-1:0]   r0_slice;

    assign start_me = Start[CORE_ID];
    assign r0_slice = Init_R0[CORE_ID*REG_SIZE +: REG_SIZE];

    // Other cores' bits of the broadcast vectors are intentionally ignored.
    logic unused_bcast;
    assign unused_bcast = ^{Start, Init_R0_Vect, Init_R0};

    always_comb begin
        state_d = state_q;
        frames_d = frames_q;
        ovf_d = ovf_q;
        r0v_d = r0v_q;
        r0val_d = r0val_q;
        wr_en = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_me) begin
                    state_d = LOAD;
                    frames_d = '0;
                    ovf_d = 1'b0;
                    r0v_d = Init_R0_Vect[CORE_ID];
                    r0val_d = Init_R0_Vect[CORE_ID] ? r0_slice : '0;
                end
            end
            LOAD: begin
                if (Insn_Valid) begin
                    if (frames_q < FW'(MAX_FRAMES)) begin
                        wr_en = 1'b1;
                        frames_d = frames_q + FW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                    if (Insn_Last) begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (Core_Done) begin
                    state_d = IDLE;
                    r0v_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            frames_q <= '0;
            ovf_q <= 1'b0;
            r0v_q <= 1'b0;
            r0val_q <= '0;
        end else begin
            state_q <= state_d;
            frames_q <= frames_d;
            ovf_q <= ovf_d;
            r0v_q <= r0v_d;
            r0val_q <= r0val_d;
        end
    end

    // Buffer contents are not reset; Frames_Loaded masks stale rows.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            buf_q[frames_q[FIW-1:0]] <= Insn_Data;
        end
    end

    logic [31:0]          fa;
    logic [31:0]          fetch_lim;
    logic [FIW-1:0]       fsel;
    logic [KW-1:0]        ksel;
    logic [FRAME_W-1:0]   frame_w;

    // Addresses beyond the loaded frames read as NOP (zero).
    always_comb begin
        fa = 32'(Fetch_Addr);
        fetch_lim = 32'(frames_q) * 32'(INSN_COUNT);
        fsel = FIW'(fa / 32'(INSN_COUNT));
        ksel = KW'(fa % 32'(INSN_COUNT));
        frame_w = buf_q[fsel];
        Fetch_Insn = '0;
        if (fa < fetch_lim) begin
            Fetch_Insn = frame_w[ksel*INSN_SIZE +: INSN_SIZE];
        end
    end

    assign Ready = (state_q == IDLE);
    assign Core_Run = (state_q == RUN);
    assign R0_Init_Valid = r0v_q;
    assign R0_Init_Value = r0val_q;
    assign Frames_Loaded = frames_q;
    assign Overflow = ovf_q;

endmodule

// File: tb/tb_core_task_receiver.sv
// Self-checking bench for core_task_receiver (CORE_ID=3).
// Table of task vectors plus reset corner sequences; fetch scoreboard.
module tb_core_task_receiver;

    localparam int CID = 3;
    localparam int NC  = 16;
    localparam int IC  = 16;
    localparam int IS  = 16;
    localparam int RS  = 8;
    localparam int MF  = 4;
    localparam int AW  = 6;
    localparam int FW  = 3;

    logic              clk;
    logic              rst;
    logic [NC-1:0]     Start;
    logic [NC-1:0]     Init_R0_Vect;
    logic [NC*RS-1:0]  Init_R0;
    logic              Insn_Valid;
    logic              Insn_Last;
    logic [IC*IS-1:0]  Insn_Data;
    logic              Ready;
    logic              Core_Run;
    logic              Core_Done;
    logic [AW-1:0]     Fetch_Addr;
    logic [IS-1:0]     Fetch_Insn;
    logic              R0_Init_Valid;
    logic [RS-1:0]     R0_Init_Value;
    logic [FW-1:0]     Frames_Loaded;
    logic              Overflow;

    core_task_receiver #(
        .CORE_ID(CID), .CORES_COUNT(NC), .INSN_COUNT(IC),
        .INSN_SIZE(IS), .REG_SIZE(RS), .MAX_FRAMES(MF)
    ) dut (
        .clk(clk), .rst(rst), .Start(Start),
        .Init_R0_Vect(Init_R0_Vect), .Init_R0(Init_R0),
        .Insn_Valid(Insn_Valid), .Insn_Last(Insn_Last),
        .Insn_Data(Insn_Data), .Ready(Ready), .Core_Run(Core_Run),
        .Core_Done(Core_Done), .Fetch_Addr(Fetch_Addr),
        .Fetch_Insn(Fetch_Insn), .R0_Init_Valid(R0_Init_Valid),
        .R0_Init_Value(R0_Init_Value), .Frames_Loaded(Frames_Loaded),
        .Overflow(Overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] start;
        logic [NC-1:0] r0_vect;
        logic [RS-1:0] r0;
        int            n;
        int            exp_frames;
        bit            exp_ovf;
        bit            exp_r0v;
        logic [RS-1:0] exp_r0val;
    } vec_t;

    int checks = 0;
    int errors = 0;

    logic [IS-1:0] exp_mem [MF*IC];
    int            mf = 0;
    logic [IS-1:0] sb_q [$];

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_scan();
        logic [IS-1:0] e;
        for (int a = 0; a < MF*IC; a++) begin
            Fetch_Addr = AW'(a);
            sb_q.push_back((a < mf*IC) ? exp_mem[a] : '0);
            #1;
            e = sb_q.pop_front();
            chk($sformatf("fetch[%0d]", a), 64'(Fetch_Insn), 64'(e));
        end
        step();
    endtask

    task automatic rand_frame(output logic [IC*IS-1:0] d);
        for (int j = 0; j < IC*IS/32; j++) d[j*32 +: 32] = $urandom;
    endtask

    task automatic run_vec(input vec_t e);
        bit sel;
        logic [IC*IS-1:0] d;
        sel = e.start[CID];
        for (int c = 0; c < NC; c++) Init_R0[c*RS +: RS] = RS'($urandom);
        Init_R0[CID*RS +: RS] = e.r0;
        Start = e.start;
        Init_R0_Vect = e.r0_vect;
        // A frame presented in the Start cycle must be ignored.
        rand_frame(d);
        Insn_Data = d;
        Insn_Valid = 1'b1;
        Insn_Last = 1'b1;
        step();
        Start = '0;
        Init_R0_Vect = '0;
        Insn_Valid = 1'b0;
        chk("ready_after_start", 64'(Ready), 64'(!sel));
        if (sel) mf = 0;
        // Last without Valid is ignored.
        step();
        Insn_Last = 1'b0;
        chk("run_after_lone_last", 64'(Core_Run), 64'd0);
        for (int i = 0; i < e.n; i++) begin
            rand_frame(d);
            Insn_Data = d;
            Insn_Valid = 1'b1;
            Insn_Last = (i == e.n - 1);
            if (sel && mf < MF) begin
                for (int k = 0; k < IC; k++) exp_mem[mf*IC + k] = d[k*IS +: IS];
                mf++;
            end
            step();
            Insn_Valid = 1'b0;
            Insn_Last = 1'b0;
            if (i < e.n - 1) chk("run_during_load", 64'(Core_Run), 64'd0);
        end
        chk("core_run", 64'(Core_Run), 64'(sel));
        chk("ready", 64'(Ready), 64'(!sel));
        chk("frames_loaded", 64'(Frames_Loaded), 64'(e.exp_frames));
        chk("overflow", 64'(Overflow), 64'(e.exp_ovf));
        chk("r0_valid", 64'(R0_Init_Valid), 64'(e.exp_r0v));
        chk("r0_value", 64'(R0_Init_Value), 64'(e.exp_r0val));
        fetch_scan();
        if (sel) begin
            Start = '1;
            step();
            Start = '0;
            chk("restart_ignored_run", 64'(Core_Run), 64'd1);
            chk("restart_ignored_frames", 64'(Frames_Loaded),
                64'(e.exp_frames));
            Core_Done = 1'b1;
            step();
            Core_Done = 1'b0;
            chk("ready_after_done", 64'(Ready), 64'd1);
            chk("run_after_done", 64'(Core_Run), 64'd0);
            chk("r0v_after_done", 64'(R0_Init_Valid), 64'd0);
            chk("frames_held", 64'(Frames_Loaded), 64'(e.exp_frames));
        end
    endtask

    vec_t vt [6];
    vec_t v6;

    initial begin
        logic [IC*IS-1:0] d;
        vt[0] = '{16'h0008, 16'h0008, 8'hA5, 2, 2, 1'b0, 1'b1, 8'hA5};
        vt[1] = '{16'h0004, 16'h0004, 8'h3C, 2, 2, 1'b0, 1'b0, 8'hA5};
        vt[2] = '{16'h0008, 16'h0008, 8'h11, 5, 4, 1'b1, 1'b1, 8'h11};
        vt[3] = '{16'h0008, 16'hFFF7, 8'h77, 1, 1, 1'b0, 1'b0, 8'h00};
        vt[4] = '{16'h0008, 16'h0008, 8'h5A, 4, 4, 1'b0, 1'b1, 8'h5A};
        vt[5] = '{16'h0018, 16'h0008, 8'hC3, 3, 3, 1'b0, 1'b1, 8'hC3};
        v6    = '{16'h0008, 16'h0008, 8'h9E, 2, 2, 1'b0, 1'b1, 8'h9E};

        rst = 1'b0;
        Start = '0;
        Init_R0_Vect = '0;
        Init_R0 = '0;
        Insn_Valid = 1'b0;
        Insn_Last = 1'b0;
        Insn_Data = '0;
        Core_Done = 1'b0;
        Fetch_Addr = '0;

        #2 rst = 1'b1;
        #1;
        chk("rst_ready", 64'(Ready), 64'd1);
        chk("rst_run", 64'(Core_Run), 64'd0);
        chk("rst_ovf", 64'(Overflow), 64'd0);
        chk("rst_frames", 64'(Frames_Loaded), 64'd0);
        chk("rst_r0v", 64'(R0_Init_Valid), 64'd0);
        chk("rst_r0val", 64'(R0_Init_Value), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        fetch_scan();

        for (int i = 0; i < 6; i++) run_vec(vt[i]);

        // Reset in the middle of LOAD discards the partial task.
        Start = 16'h0008;
        step();
        Start = '0;
        rand_frame(d);
        Insn_Data = d;
        Insn_Valid = 1'b1;
        step();
        Insn_Valid = 1'b0;
        chk("midload_frames", 64'(Frames_Loaded), 64'd1);
        #3 rst = 1'b1;
        #1;
        mf = 0;
        chk("midrst_ready", 64'(Ready), 64'd1);
        chk("midrst_frames", 64'(Frames_Loaded), 64'd0);
        chk("midrst_run", 64'(Core_Run), 64'd0);
        chk("midrst_r0v", 64'(R0_Init_Valid), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        run_vec(v6);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
